// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute and decodes datapath controls.
// Optional `define BNE_EN adds the BNEEX branch-not-equal state (encoding 13).
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_RTYPEEX = 4'd7;
    localparam logic [3:0] S_RTYPEWB = 4'd8;
    localparam logic [3:0] S_BEQEX   = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_BNEEX   = 4'd13;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic [3:0] state_q, state_d;
    logic       op_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // op only matters in DECODE and MEMADR; elsewhere it is ignored.
    always_comb begin
        op_legal = 1'b1;
        state_d  = state_q;
        case (state_q)
            S_RST:     state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        pcen       = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = zero;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
`ifdef BNE_EN
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = ~zero;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expected state+control vectors queued per step, popped at negedge.
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, illegal_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] exp_q[$];

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {state, mem_req, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                       alusrca, alusrcb, pcsrc, aluop, pcen, illegal_op};

    // {state, mem_req, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, pcen, illegal}
    function automatic logic [19:0] mk(input logic [3:0] st, input logic mreq, input logic mw,
                                       input logic ir, input logic rw, input logic io,
                                       input logic m2r, input logic rd, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [1:0] aop, input logic pce, input logic ill);
        return {st, mreq, mw, ir, rw, io, m2r, rd, asa, asb, pcs, aop, pce, ill};
    endfunction

    logic [19:0] V_RST, V_FRDY, V_FWAIT, V_DEC, V_DECILL, V_MADR, V_MRD, V_MWR, V_MWB;
    logic [19:0] V_RTEX, V_RTWB, V_BEQ1, V_BEQ0, V_ADEX, V_ADWB, V_JEX, V_BNE1;

    task automatic check_now(input string tag);
        logic [19:0] e;
        e = exp_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%05h expected=%05h (state %0d vs %0d)", tag, obs, e, obs[19:16], e[19:16]);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] o, input logic z, input logic mr,
                        input logic [19:0] e);
        op = o; zero = z; mem_ready = mr;
        exp_q.push_back(e);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        V_RST    = mk(4'd0, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_FRDY   = mk(4'd1, 1,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 1,0);
        V_FWAIT  = mk(4'd1, 1,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        V_DEC    = mk(4'd2, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
        V_DECILL = mk(4'd2, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
        V_MADR   = mk(4'd3, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        V_MRD    = mk(4'd4, 1,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_MWB    = mk(4'd5, 0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_MWR    = mk(4'd6, 1,1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_RTEX   = mk(4'd7, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10, 0,0);
        V_RTWB   = mk(4'd8, 0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_BEQ1   = mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
        V_BEQ0   = mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,0);
        V_ADEX   = mk(4'd10,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        V_ADWB   = mk(4'd11,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        V_JEX    = mk(4'd12,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 1,0);
        V_BNE1   = mk(4'd13,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);

        // Reset held across edges: outputs all zero even with mem_ready/zero high.
        #1;
        step("rst_hold0", 6'b000000, 1, 1, V_RST);
        step("rst_hold1", 6'b000000, 1, 1, V_RST);
        rst_n = 1'b1;
        step("rst_release", 6'b000000, 0, 1, V_RST);

        // Fetch wait, then R-type; op changes in RTYPEEX must not matter.
        step("fetch_wait", 6'b000000, 0, 0, V_FWAIT);
        step("rt_fetch", 6'b000000, 0, 1, V_FRDY);
        step("rt_decode", 6'b000000, 0, 1, V_DEC);
        step("rt_ex", 6'b100011, 0, 1, V_RTEX);
        step("rt_wb", 6'b101011, 0, 1, V_RTWB);

        // lw with two wait cycles in MEMRD
        step("lw_fetch", 6'b100011, 0, 1, V_FRDY);
        step("lw_decode", 6'b100011, 0, 1, V_DEC);
        step("lw_madr", 6'b100011, 0, 1, V_MADR);
        step("lw_rd_w0", 6'b000000, 0, 0, V_MRD);
        step("lw_rd_w1", 6'b000000, 0, 0, V_MRD);
        step("lw_rd", 6'b000000, 0, 1, V_MRD);
        step("lw_wb", 6'b000000, 0, 1, V_MWB);

        // sw with one wait cycle
        step("sw_fetch", 6'b101011, 0, 1, V_FRDY);
        step("sw_decode", 6'b101011, 0, 1, V_DEC);
        step("sw_madr", 6'b101011, 0, 1, V_MADR);
        step("sw_wr_w", 6'b000000, 0, 0, V_MWR);
        step("sw_wr", 6'b000000, 0, 1, V_MWR);

        // beq taken / not taken
        step("beq1_fetch", 6'b000100, 1, 1, V_FRDY);
        step("beq1_decode", 6'b000100, 1, 1, V_DEC);
        step("beq1_ex", 6'b000100, 1, 1, V_BEQ1);
        step("beq0_fetch", 6'b000100, 0, 1, V_FRDY);
        step("beq0_decode", 6'b000100, 0, 1, V_DEC);
        step("beq0_ex", 6'b000100, 0, 1, V_BEQ0);

        // addi and j
        step("addi_fetch", 6'b001000, 0, 1, V_FRDY);
        step("addi_decode", 6'b001000, 0, 1, V_DEC);
        step("addi_ex", 6'b001000, 0, 1, V_ADEX);
        step("addi_wb", 6'b001000, 0, 1, V_ADWB);
        step("j_fetch", 6'b000010, 0, 1, V_FRDY);
        step("j_decode", 6'b000010, 0, 1, V_DEC);
        step("j_ex", 6'b000010, 0, 1, V_JEX);

        // illegal opcode returns straight to FETCH
        step("ill_fetch", 6'b111111, 0, 1, V_FRDY);
        step("ill_decode", 6'b111111, 0, 1, V_DECILL);

        // bne, zero=0
        step("bne_fetch", 6'b000101, 0, 1, V_FRDY);
`ifdef BNE_EN
        step("bne_decode", 6'b000101, 0, 1, V_DEC);
        step("bne_ex", 6'b000101, 0, 1, V_BNE1);
`else
        step("bne_decode_ill", 6'b000101, 0, 1, V_DECILL);
`endif

        // Async reset in the middle of a MEMWR wait
        step("rsw_fetch", 6'b101011, 0, 1, V_FRDY);
        step("rsw_decode", 6'b101011, 0, 1, V_DEC);
        step("rsw_madr", 6'b101011, 0, 1, V_MADR);
        mem_ready = 1'b0;
        exp_q.push_back(V_MWR);
        @(negedge clk);
        check_now("rsw_wr_wait");
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(V_RST);
        check_now("rsw_async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("rsw_post_rst", 6'b101011, 0, 0, V_RST);
        step("rsw_refetch", 6'b101011, 0, 0, V_FWAIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port op, input, 6 bits: instruction opcode from the instruction register.
REQ-004 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access completes in the cycle it is high.
REQ-006 The block SHALL have port mem_req, output, 1 bit: memory access request.
REQ-007 The block SHALL have port memwrite, output, 1 bit: memory write request.
REQ-008 The block SHALL have ports irwrite, regwrite, iord, memtoreg, regdst and alusrca, outputs, 1 bit each: datapath enables and selects.
- regdst drives the 5-bit write-register mux: 0 = rt, 1 = rd.
REQ-009 The block SHALL have ports alusrcb, pcsrc and aluop, outputs, 2 bits each: datapath selects.
REQ-010 The block SHALL have port pcen, output, 1 bit: PC load enable.
REQ-011 The block SHALL have port illegal_op, output, 1 bit: unsupported opcode detected.
REQ-012 The block SHALL have port state, output, 4 bits: current state, for debug.

Function
REQ-013 States and encodings SHALL be:
- RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
- RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12, BNEEX=13
REQ-014 Transitions SHALL be:
- RST->FETCH.
- FETCH->DECODE when mem_ready=1; otherwise FETCH holds.
- DECODE dispatches on op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH
REQ-015 Transitions SHALL continue as:
- MEMADR->MEMRD when op=100011, else MEMWR.
- MEMRD->MEMWB when mem_ready=1; otherwise MEMRD holds.
- MEMWR->FETCH when mem_ready=1; otherwise MEMWR holds.
- MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX and BNEEX -> FETCH.
- RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-016 Outputs SHALL be decoded from state and inputs in the same cycle; every output not listed for a state SHALL be 0.
REQ-017 FETCH outputs SHALL be: mem_req=1, alusrcb=01; irwrite=1 and pcen=1 only in the cycle mem_ready=1.
REQ-018 DECODE SHALL drive alusrcb=11 and SHALL drive illegal_op=1 when op is unsupported.
REQ-019 MEMADR SHALL drive alusrca=1 and alusrcb=10.
REQ-020 MEMRD SHALL drive mem_req=1 and iord=1.
REQ-021 MEMWR SHALL drive mem_req=1, iord=1 and memwrite=1 in every cycle until mem_ready=1.
REQ-022 MEMWB SHALL drive regwrite=1, memtoreg=1 and regdst=0.
REQ-023 RTYPEEX SHALL drive alusrca=1 and aluop=10.
REQ-024 RTYPEWB SHALL drive regwrite=1 and regdst=1.
REQ-025 BEQEX SHALL drive alusrca=1, aluop=01, pcsrc=01, and pcen=zero.
REQ-026 ADDIEX SHALL drive alusrca=1 and alusrcb=10.
REQ-027 ADDIWB SHALL drive regwrite=1 and regdst=0.
REQ-028 JEX SHALL drive pcsrc=10 and pcen=1.
REQ-029 Instruction latency SHALL be, with mem_ready held at 1:
- R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
- Each wait cycle (mem_ready=0) SHALL add exactly one cycle.
REQ-030 regwrite and memwrite SHALL never be 1 in the same cycle.
REQ-031 op SHALL be sampled in DECODE and MEMADR only; changes in op during other states SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL force state=RST immediately, regardless of clk.
REQ-033 In RST every output SHALL be 0, including pcen and memwrite.
REQ-034 Reset asserted mid-instruction, including during a memory wait, SHALL abandon that instruction.
REQ-035 After rst_n rises, the first clk edge SHALL move to FETCH.

Configuration
REQ-036 With BNE_EN defined, DECODE SHALL map op=000101 to BNEEX.
- BNEEX SHALL drive alusrca=1, aluop=01, pcsrc=01, and pcen=~zero.
REQ-037 With BNE_EN undefined:
- op=000101 SHALL be illegal (illegal_op=1, DECODE->FETCH).
- Encoding 13 SHALL be unreachable.

Verification
REQ-038 Reset: rst_n=0 mid-MEMWR with memwrite=1 -> state=0 and memwrite=0 immediately; after release, state=1 on the next edge.
REQ-039 R-type: op=000000, mem_ready=1 -> states 1,2,7,8,1; RTYPEWB has regwrite=1, regdst=1.
REQ-040 lw with wait: op=100011, mem_ready low for 2 cycles in MEMRD -> states 1,2,3,4,4,4,5,1; MEMWB has regdst=0, memtoreg=1.
REQ-041 beq: op=000100 -> with zero=1, pcen=1 in BEQEX; with zero=0, pcen=0; in both cases the next state is 1.
REQ-042 Illegal: op=111111 -> illegal_op=1 in DECODE, next state 1, no regwrite or memwrite pulse.
REQ-043 bne: op=000101, zero=0 -> with BNE_EN, state 13 and pcen=1; without BNE_EN, illegal_op=1.
